// File: rtl/alu_seq_pkg.sv
// ----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU command sequencer:
//   - ALU control-word encodings ({MODE,OP,DIR}) driven on Control
//   - cmd_t, the command record carried through the command FIFO
//   - state_e, the issue FSM state type
//   - default sizing parameters
// ----------------------------------------------------------------------------
package alu_seq_pkg;

    // Default FIFO depth (entries, power of two, at least 2).
    localparam int DEPTH_DEF   = 4;

    // Default width of the per-command repeat count.
    localparam int COUNT_W_DEF = 4;

    // Width of the count field inside cmd_t. A package struct cannot follow
    // a module parameter, so the field is sized for the widest supported
    // COUNT_W. Narrower counts are zero-extended on entry, and the constant
    // upper bits are trimmed away by synthesis.
    localparam int COUNT_W_MAX = 16;

    // ALU control-word encodings.
    localparam logic [2:0] CTRL_ROTR = 3'b000;
    localparam logic [2:0] CTRL_ROTL = 3'b001;
    localparam logic [2:0] CTRL_SUB  = 3'b100;
    localparam logic [2:0] CTRL_ADD  = 3'b110;

    // One queued command.
    typedef struct packed {
        logic [2:0]             ctrl;
        logic [7:0]             a;
        logic [7:0]             b;
        logic [COUNT_W_MAX-1:0] count;
    } cmd_t;

    // Issue FSM states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// ----------------------------------------------------------------------------
// cmd_fifo
// Synchronous command FIFO with an occupancy count. Reads are taken straight
// from storage at the read pointer, so an entry written on one edge can only
// be popped on a later edge (there is no write-to-read bypass).
//
// Ports
//   clk          clock, all state on the rising edge
//   rst_n        asynchronous active-low reset (pointers and level to 0)
//   push_i       write request, ignored while full
//   push_data_i  command to write
//   pop_i        read request, ignored while empty
//   pop_data_o   command at the head of the FIFO
//   full_o       level == DEPTH
//   empty_o      level == 0
//   level_o      number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  cmd_t                   push_data_i,
    input  logic                   pop_i,
    output cmd_t                   pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: storage carries no reset; the level count alone decides which
    // entries are meaningful, so clearing the array would only add reset
    // fan-out to every bit.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: clocked state is always assigned with <= so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by overflow.
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the level unchanged.
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign level_o    = level_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// alu_cmd_sequencer
// Queues ALU commands and plays each one onto an external registered ALU
// stage for Count+1 consecutive cycles. Between commands the ALU is held in
// "hold mode" (ADD of its own result and zero) so its result is preserved.
//
// Parameters
//   DEPTH      command FIFO entries (power of two, at least 2)
//   COUNT_W    width of Cmd_Count
//
// Ports
//   CLK         sole clock, rising edge
//   RST_N       asynchronous active-low reset
//   Cmd_Valid   command offered
//   Cmd_Ready   FIFO not full; a command is accepted when both are high
//   Cmd_Ctrl    {MODE,OP,DIR} control word for the command
//   Cmd_A/B     operands
//   Cmd_Count   number of issue cycles minus one
//   Alu_Result  registered ALU result fed back for hold mode
//   Input_1/2   ALU operands
//   Control     ALU control word
//   Busy        high while a command is being issued
//   Done        one-cycle pulse after each command's final issue edge
//   Level       number of queued (not yet started) commands
// ----------------------------------------------------------------------------
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int COUNT_W = COUNT_W_DEF
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   Cmd_Valid,
    output logic                   Cmd_Ready,
    input  logic [2:0]             Cmd_Ctrl,
    input  logic [7:0]             Cmd_A,
    input  logic [7:0]             Cmd_B,
    input  logic [COUNT_W-1:0]     Cmd_Count,
    input  logic [7:0]             Alu_Result,
    output logic [7:0]             Input_1,
    output logic [7:0]             Input_2,
    output logic [2:0]             Control,
    output logic                   Busy,
    output logic                   Done,
    output logic [$clog2(DEPTH):0] Level
);

    cmd_t                   push_cmd;
    cmd_t                   pop_cmd;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;

    state_e                 state_q;
    logic [2:0]             ctrl_q;
    logic [7:0]             a_q;
    logic [7:0]             b_q;
    logic [COUNT_W_MAX-1:0] cnt_q;
    logic                   done_q;

    assign push_cmd = '{
        ctrl:  Cmd_Ctrl,
        a:     Cmd_A,
        b:     Cmd_B,
        count: COUNT_W_MAX'(Cmd_Count)
    };

    cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (CLK),
        .rst_n       (RST_N),
        .push_i      (Cmd_Valid),
        .push_data_i (push_cmd),
        .pop_i       (fifo_pop),
        .pop_data_o  (pop_cmd),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (Level)
    );

    assign Cmd_Ready = !fifo_full;

    // Pop whenever the issue slot is free on this edge: either nothing is
    // running, or the running command is on its final issue cycle. The
    // latter chains the next command in with no idle cycle in between.
    assign fifo_pop = !fifo_empty && ((state_q == ST_IDLE) || (cnt_q == '0));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            ctrl_q  <= CTRL_ADD;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            // The final issue edge of a command is the one seen with the
            // counter at zero; Done follows it by one cycle.
            done_q <= (state_q == ST_ISSUE) && (cnt_q == '0);

            if (fifo_pop) begin
                state_q <= ST_ISSUE;
                ctrl_q  <= pop_cmd.ctrl;
                a_q     <= pop_cmd.a;
                b_q     <= pop_cmd.b;
                cnt_q   <= pop_cmd.count;
            end else if (state_q == ST_ISSUE) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - COUNT_W_MAX'(1);
                end else begin
                    state_q <= ST_IDLE;
                end
            end
        end
    end

    assign Busy = (state_q == ST_ISSUE);
    assign Done = done_q;

    // NOTE: every signal driven here gets a value on every path, so the
    // block stays purely combinational and infers no latch.
    always_comb begin
        Control = CTRL_ADD;
        Input_1 = Alu_Result;
        Input_2 = 8'h00;
        if (state_q == ST_ISSUE) begin
            Control = ctrl_q;
            Input_1 = a_q;
            Input_2 = b_q;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Bench for alu_cmd_sequencer. A registered ALU model closes the loop from
// Control/Input_1/Input_2 back to Alu_Result. A command-level reference model
// turns every accepted command into its sequence of expected ALU results
// (one per issue edge); a monitor pops that queue each time the sequencer
// issues and checks result, Done and hold behaviour.
// ----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    logic       CLK;
    logic       RST_N;
    logic       Cmd_Valid;
    logic       Cmd_Ready;
    logic [2:0] Cmd_Ctrl;
    logic [7:0] Cmd_A;
    logic [7:0] Cmd_B;
    logic [3:0] Cmd_Count;
    logic [7:0] Alu_Result;
    logic [7:0] Input_1;
    logic [7:0] Input_2;
    logic [2:0] Control;
    logic       Busy;
    logic       Done;
    logic [2:0] Level;

    alu_cmd_sequencer #(
        .DEPTH   (4),
        .COUNT_W (4)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .Cmd_Valid  (Cmd_Valid),
        .Cmd_Ready  (Cmd_Ready),
        .Cmd_Ctrl   (Cmd_Ctrl),
        .Cmd_A      (Cmd_A),
        .Cmd_B      (Cmd_B),
        .Cmd_Count  (Cmd_Count),
        .Alu_Result (Alu_Result),
        .Input_1    (Input_1),
        .Input_2    (Input_2),
        .Control    (Control),
        .Busy       (Busy),
        .Done       (Done),
        .Level      (Level)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // External ALU stage: rotates act on the ALU's own result register.
    logic [7:0] alu_q;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            alu_q <= 8'h00;
        end else begin
            case (Control)
                CTRL_ADD:  alu_q <= Input_1 + Input_2;
                CTRL_SUB:  alu_q <= Input_1 - Input_2;
                CTRL_ROTL: alu_q <= {alu_q[6:0], alu_q[7]};
                CTRL_ROTR: alu_q <= {alu_q[0], alu_q[7:1]};
                default:   alu_q <= alu_q;
            endcase
        end
    end
    assign Alu_Result = alu_q;

    // ------------------------------------------------------------------
    // Scoreboard and reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] res;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] acc;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         last_wait = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // A command is Count+1 ALU operations applied in order to the running
    // result; each one yields one expected Alu_Result.
    task automatic model_cmd(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b, input int n);
        exp_t e;
        for (int k = 0; k <= n; k++) begin
            case (c)
                CTRL_ADD:  acc = a + b;
                CTRL_SUB:  acc = a - b;
                CTRL_ROTL: acc = (acc << 1) | (acc >> 7);
                CTRL_ROTR: acc = (acc >> 1) | (acc << 7);
                default:   acc = acc;
            endcase
            e.res  = acc;
            e.last = (k == n);
            exp_q.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b, input int n);
        int waited;
        waited = 0;
        while (!Cmd_Ready && waited < 400) begin
            @(negedge CLK);
            waited++;
        end
        last_wait = waited;
        if (!Cmd_Ready) begin
            fail_now("push_ready_timeout");
        end else begin
            Cmd_Valid = 1'b1;
            Cmd_Ctrl  = c;
            Cmd_A     = a;
            Cmd_B     = b;
            Cmd_Count = 4'(n);
            model_cmd(c, a, b, n);
            @(negedge CLK);
            Cmd_Valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(Busy == 1'b0 && Level == 3'd0) && k < 200) begin
            @(negedge CLK);
            k++;
        end
        if (Busy !== 1'b0 || Level !== 3'd0) fail_now("drain_timeout");
        @(negedge CLK);
    endtask

    // Monitor: Busy during a cycle means the ALU samples a command on the
    // next edge, whose result is visible at the following negedge.
    initial begin
        logic       pend;
        logic [7:0] m_res;
        exp_t       e;
        pend  = 1'b0;
        m_res = 8'h00;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                pend  = 1'b0;
                m_res = 8'h00;
            end else begin
                if (pend) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_issue");
                    end else begin
                        e = exp_q.pop_front();
                        check("result", Alu_Result, e.res);
                        check("done_final", Done, e.last);
                        m_res = e.res;
                    end
                end else begin
                    check("hold_result", Alu_Result, m_res);
                    check("done_idle", Done, 0);
                end
                pend = Busy;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [2:0] codes [4];
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] sum;

        codes[0] = CTRL_ROTR;
        codes[1] = CTRL_ROTL;
        codes[2] = CTRL_SUB;
        codes[3] = CTRL_ADD;

        RST_N     = 1'b0;
        Cmd_Valid = 1'b0;
        Cmd_Ctrl  = 3'b000;
        Cmd_A     = 8'h00;
        Cmd_B     = 8'h00;
        Cmd_Count = 4'h0;
        acc       = 8'h00;

        repeat (3) @(negedge CLK);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_level", Level, 0);
        check("rst_ready", Cmd_Ready, 1);
        check("rst_control", Control, 3'b110);
        check("rst_in2", Input_2, 0);
        check("rst_in1_hold", Input_1, Alu_Result);
        #2 RST_N = 1'b1;

        // Single one-cycle ADD: latency, Done pulse, hold afterwards.
        push(CTRL_ADD, 8'd5, 8'd3, 0);
        check("first_accept_level", Level, 1);
        check("no_bypass_busy", Busy, 0);
        @(negedge CLK);
        check("issue_busy", Busy, 1);
        check("issue_level", Level, 0);
        check("issue_ctrl", Control, CTRL_ADD);
        check("issue_in1", Input_1, 8'd5);
        check("issue_in2", Input_2, 8'd3);
        @(negedge CLK);
        check("add_result", Alu_Result, 8'd8);
        check("add_busy_off", Busy, 0);
        check("add_done", Done, 1);
        @(negedge CLK);
        check("add_done_once", Done, 0);
        repeat (10) @(negedge CLK);
        check("add_hold_result", Alu_Result, 8'd8);
        check("hold_ctrl", Control, CTRL_ADD);
        check("hold_in1", Input_1, 8'd8);
        check("hold_in2", Input_2, 8'd0);

        // ADD 0x81 then ROTL x3.
        push(CTRL_ADD, 8'h81, 8'h00, 0);
        push(CTRL_ROTL, 8'($urandom), 8'($urandom), 2);
        wait_idle();
        check("rotl_final", Alu_Result, 8'h0C);

        // Back-to-back commands: no bubble, consecutive Done.
        push(CTRL_SUB, 8'd10, 8'd3, 0);
        push(CTRL_ADD, 8'd1, 8'd1, 0);
        check("b2b_busy1", Busy, 1);
        check("b2b_done1", Done, 0);
        check("b2b_ctrl1", Control, CTRL_SUB);
        @(negedge CLK);
        check("b2b_busy2", Busy, 1);
        check("b2b_done2", Done, 1);
        check("b2b_res1", Alu_Result, 8'd7);
        @(negedge CLK);
        check("b2b_busy_off", Busy, 0);
        check("b2b_done3", Done, 1);
        check("b2b_res2", Alu_Result, 8'd2);
        @(negedge CLK);
        check("b2b_done_off", Done, 0);

        // Fill behind a long command.
        push(CTRL_ROTR, 8'($urandom), 8'($urandom), 15);
        for (int i = 0; i < 4; i++) push(CTRL_ADD, 8'($urandom), 8'($urandom), 0);
        check("full_level", Level, 4);
        check("full_ready", Cmd_Ready, 0);
        push(CTRL_SUB, 8'($urandom), 8'($urandom), 1);
        check("full_wait_cycles", last_wait, 13);
        wait_idle();

        // Asynchronous reset mid-command.
        push(CTRL_ROTL, 8'($urandom), 8'($urandom), 15);
        push(CTRL_ADD, 8'd1, 8'd2, 0);
        push(CTRL_SUB, 8'd4, 8'd1, 0);
        repeat (2) @(negedge CLK);
        check("pre_rst_busy", Busy, 1);
        check("pre_rst_level", Level, 2);
        #2 RST_N = 1'b0;
        exp_q.delete();
        acc = 8'h00;
        #1;
        check("arst_busy", Busy, 0);
        check("arst_level", Level, 0);
        check("arst_ready", Cmd_Ready, 1);
        check("arst_control", Control, 3'b110);
        check("arst_in2", Input_2, 0);
        check("arst_done", Done, 0);
        repeat (2) @(negedge CLK);
        check("arst_still_idle", Busy, 0);
        #2 RST_N = 1'b1;
        push(CTRL_ADD, 8'd9, 8'd9, 0);
        check("post_rst_accept", Level, 1);
        wait_idle();
        check("post_rst_result", Alu_Result, 8'd18);

        // Six single-cycle ADDs one at a time: pointer wrap.
        for (int i = 0; i < 6; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            sum = ra + rb;
            push(CTRL_ADD, ra, rb, 0);
            wait_idle();
            check("wrap_result", Alu_Result, sum);
        end

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            push(codes[$urandom_range(0, 3)], 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
        wait_idle();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
